// File: rtl/inst_issuer.sv
// inst_issuer: host-side instruction transmitter. A host loads a short
// program into a local buffer, pulses start, and the block replays the
// program one or more times over a valid/ready port into the accelerator.
//
// Handshake: inst_valid_o is a pure function of registered state. Once it
// rises, inst_o and inst_valid_o stay frozen until a cycle where
// inst_valid_o && inst_ready_i is seen at a rising edge; that edge is the
// transfer. inst_ready_i never feeds inst_valid_o or inst_o.
module inst_issuer #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [INST_W-1:0] load_data_i,
  output logic              load_ready_o,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [7:0]        loop_count_i,
  input  logic              abort_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       issued_cnt_o,
  output logic [1:0]        state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [7:0]        passes_q;
  logic [15:0]       issued_q;
  logic              abort_pending_q;
  logic [INST_W-1:0] mem [DEPTH];

  logic idle;
  logic start_go;
  logic load_fire;
  logic hs;
  logic last_word;
  logic last_pass;
  logic stop_now;
  logic finish;

  assign idle      = (state_q == IDLE);
  assign start_go  = idle && start_i;
  // Ready is forced low while reset is held so the port looks quiet.
  assign load_ready_o = rst_i && idle && (count_q != FULL) && !clear_i;
  // Start takes priority: a load offered in the start cycle is not taken.
  assign load_fire = load_valid_i && load_ready_o && !start_i;
  assign hs        = (state_q == ISSUE) && inst_ready_i;
  assign last_word = ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));
  assign last_pass = (passes_q == 8'd1);
  assign stop_now  = abort_pending_q || abort_i;
  assign finish    = hs && (stop_now || (last_word && last_pass));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (count_q == '0) ? DONE : ISSUE;
      ISSUE:   if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    inst_valid_o = (state_q == ISSUE);
    busy_o       = (state_q == ISSUE);
    done_o       = (state_q == DONE);
    inst_o       = (state_q == ISSUE) ? mem[rd_ptr_q] : '0;
    issued_cnt_o = issued_q;
    state_o      = state_q;
  end

  // Buffer bookkeeping, read pointer, pass counter and issue counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      passes_q        <= '0;
      issued_q        <= '0;
      abort_pending_q <= 1'b0;
    end else begin
      if (start_go) begin
        issued_q        <= '0;
        rd_ptr_q        <= '0;
        abort_pending_q <= 1'b0;
        passes_q        <= (loop_count_i == 8'd0) ? 8'd1 : loop_count_i;
      end else if (idle && clear_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
      end else if (load_fire) begin
        count_q  <= count_q + CNT_W'(1);
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end

      if (hs) begin
        if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
        if (!stop_now) begin
          if (last_word) begin
            passes_q <= passes_q - 8'd1;
            rd_ptr_q <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          end
        end
      end else if ((state_q == ISSUE) && abort_i) begin
        abort_pending_q <= 1'b1;
      end
    end
  end

  // Program storage; contents are not reset and survive across runs.
  always_ff @(posedge clk_i) begin
    if (load_fire) mem[wr_ptr_q] <= load_data_i;
  end

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: random program words and ready patterns, checked
// against a program queue and an expected issue queue built from the
// replay rules (repeat the program max(loops,1) times, cut after an abort).
module tb_inst_issuer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        load_ready_o;
  logic        clear_i;
  logic        start_i;
  logic [7:0]  loop_count_i;
  logic        abort_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] issued_cnt_o;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prog[$];

  inst_issuer #(.DEPTH(16), .INST_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .clear_i(clear_i), .start_i(start_i), .loop_count_i(loop_count_i), .abort_i(abort_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .busy_o(busy_o), .done_o(done_o), .issued_cnt_o(issued_cnt_o), .state_o(state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Hold load_valid_i for a number of cycles with random words.
  task automatic load_hold(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check("load_ready", {31'b0, load_ready_o}, {31'b0, prog.size() < 16});
      load_valid_i = 1'b1;
      load_data_i  = $urandom;
      if (prog.size() < 16) prog.push_back(load_data_i);
      tick();
    end
    load_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i      = 1'b1;
    load_valid_i = 1'b1;
    load_data_i  = $urandom;
    #1;
    check("ready_during_clear", {31'b0, load_ready_o}, 32'd0);
    tick();
    clear_i      = 1'b0;
    load_valid_i = 1'b0;
    prog = {};
    #1;
    check("ready_after_clear", {31'b0, load_ready_o}, 32'd1);
  endtask

  // One start-to-done run. rand_ready: random backpressure; stall_idx:
  // hold ready low 5 cycles on that word; abort_idx: pulse abort on that word.
  task automatic run_program(input int loops, input bit rand_ready,
                             input int stall_idx, input int abort_idx);
    logic [31:0] exp_q[$];
    int passes, n_done, stall_left, cyc;
    bit finished, abort_seen;
    passes = (loops == 0) ? 1 : loops;
    exp_q = {};
    for (int p = 0; p < passes; p++)
      foreach (prog[i]) exp_q.push_back(prog[i]);
    if (abort_idx >= 0 && abort_idx < exp_q.size())
      while (exp_q.size() > abort_idx + 1) void'(exp_q.pop_back());

    start_i      = 1'b1;
    loop_count_i = 8'(loops);
    tick();
    start_i = 1'b0;

    if (exp_q.size() == 0) begin
      check("empty_done", {31'b0, done_o}, 32'd1);
      check("empty_valid", {31'b0, inst_valid_o}, 32'd0);
      check("empty_issued", {16'b0, issued_cnt_o}, 32'd0);
      tick();
      check("empty_done_clr", {31'b0, done_o}, 32'd0);
      return;
    end

    n_done = 0; stall_left = 5; cyc = 0; finished = 0; abort_seen = 0;
    while (!finished && cyc < 2000) begin
      check("valid", {31'b0, inst_valid_o}, 32'd1);
      check("busy", {31'b0, busy_o}, 32'd1);
      check("done_low", {31'b0, done_o}, 32'd0);
      check("inst", inst_o, exp_q[0]);
      check("issued_run", {16'b0, issued_cnt_o}, n_done);
      if (n_done == stall_idx && stall_left > 0) begin
        inst_ready_i = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        inst_ready_i = 1'($urandom_range(0, 1));
      end else begin
        inst_ready_i = 1'b1;
      end
      if (n_done == abort_idx && !abort_seen) begin
        abort_i = 1'b1;
        inst_ready_i = 1'b0;
        abort_seen = 1'b1;
      end else begin
        abort_i = 1'b0;
      end
      if (inst_ready_i) begin
        void'(exp_q.pop_front());
        n_done++;
        if (exp_q.size() == 0) finished = 1'b1;
      end
      tick();
      cyc++;
    end
    inst_ready_i = 1'b0;
    abort_i      = 1'b0;
    if (!finished) check("run_timeout", 32'd0, 32'd1);
    check("done", {31'b0, done_o}, 32'd1);
    check("done_valid", {31'b0, inst_valid_o}, 32'd0);
    check("done_busy", {31'b0, busy_o}, 32'd0);
    check("issued_final", {16'b0, issued_cnt_o}, n_done);
    tick();
    check("idle_done", {31'b0, done_o}, 32'd0);
    check("idle_issued", {16'b0, issued_cnt_o}, n_done);
  endtask

  initial begin
    rst_i = 1'b0; load_valid_i = 1'b0; load_data_i = '0; clear_i = 1'b0;
    start_i = 1'b0; loop_count_i = '0; abort_i = 1'b0; inst_ready_i = 1'b0;
    tick();
    tick();
    check("rst_load_ready", {31'b0, load_ready_o}, 32'd0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_issued", {16'b0, issued_cnt_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    rst_i = 1'b1;
    #1;

    run_program(1, 1'b0, -1, -1);   // empty buffer
    load_hold(3);
    run_program(1, 1'b0, -1, -1);   // basic run
    run_program(1, 1'b0, 1, -1);    // stall on second word
    run_program(2, 1'b0, -1, -1);
    run_program(0, 1'b0, -1, -1);
    run_program(3, 1'b1, -1, -1);

    do_clear();
    load_hold(4);
    run_program(1, 1'b0, 1, 1);     // abort during second word

    do_clear();
    load_hold(20);                  // fills to 16
    run_program(2, 1'b1, -1, -1);
    run_program(1, 1'b0, 5, 9);

    do_clear();
    run_program(2, 1'b0, -1, -1);   // empty after clear

    // Reset in the middle of a run.
    load_hold(5);
    start_i = 1'b1; loop_count_i = 8'd1;
    tick();
    start_i = 1'b0; inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    tick();
    check("pre_rst_issued", {16'b0, issued_cnt_o}, 32'd1);
    check("pre_rst_inst", inst_o, prog[1]);
    rst_i = 1'b0;
    tick();
    check("mid_rst_load_ready", {31'b0, load_ready_o}, 32'd0);
    check("mid_rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check("mid_rst_done", {31'b0, done_o}, 32'd0);
    check("mid_rst_issued", {16'b0, issued_cnt_o}, 32'd0);
    check("mid_rst_inst", inst_o, 32'd0);
    rst_i = 1'b1;
    prog = {};
    #1;
    check("post_rst_load_ready", {31'b0, load_ready_o}, 32'd1);
    run_program(1, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
